fp_divider: RTL and testbench

//  IEEE-754 single-precision divider c = a / b; inverse companion of the FFT pipelined multiplier.

---
 rtl/fp_divider_pkg.sv | 45 ++++
 rtl/fp_div_mant_step.sv | 28 ++
 rtl/fp_divider.sv | 177 +++++++++++++++++
 tb/tb_fp_divider.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_divider_pkg.sv
// Shared FP32 field constants, FSM state encoding and operand classes for fp_divider.
package fp_divider_pkg;

    localparam int unsigned FRAC_W = 23;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 24;
    localparam int unsigned QUO_W  = 26;
    localparam int unsigned REM_W  = 25;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [30:0] INF_MAG  = 31'h7F800000;
    localparam logic [30:0] ZERO_MAG = 31'h00000000;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StNorm,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ClsZero,
        ClsNorm,
        ClsInf,
        ClsNan
    } class_e;

    // Denormals (exp == 0) classify as zero, which flushes them before any further use.
    function automatic class_e classify(input logic [31:0] x);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        e = x[30:23];
        f = x[22:0];
        if (e == '0) begin
            return ClsZero;
        end else if (e == '1) begin
            return (f == '0) ? ClsInf : ClsNan;
        end
        return ClsNorm;
    endfunction

endpackage

// File: rtl/fp_div_mant_step.sv
// Combinational restoring-division slice: ITER_PER_CYCLE quotient bits per call.
module fp_div_mant_step
    import fp_divider_pkg::*;
#(
    parameter int unsigned ITER_PER_CYCLE = 1
) (
    input  logic [REM_W-1:0]          rem_i,
    input  logic [MANT_W-1:0]         div_i,
    output logic [REM_W-1:0]          rem_o,
    output logic [ITER_PER_CYCLE-1:0] q_o
);

    always_comb begin
        logic [REM_W-1:0] r;
        r   = rem_i;
        q_o = '0;
        for (int i = 0; i < int'(ITER_PER_CYCLE); i++) begin
            if (r >= {1'b0, div_i}) begin
                r = r - {1'b0, div_i};
                q_o[ITER_PER_CYCLE-1-i] = 1'b1;
            end
            // r < div_i here, so the shifted value still fits in REM_W bits
            r = {r[REM_W-2:0], 1'b0};
        end
        rem_o = r;
    end

endmodule

// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider c = a / b with an iterative restoring mantissa divider.
// Build option FP_DIV_RNE_EN selects round-to-nearest-even; otherwise results truncate.
module fp_divider
    import fp_divider_pkg::*;
#(
    parameter int unsigned ITER_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] c
);

    localparam int unsigned        NDIV      = (QUO_W + ITER_PER_CYCLE - 1) / ITER_PER_CYCLE;
    localparam logic [4:0]         CNT_LAST  = 5'(NDIV - 1);
    localparam logic signed [9:0]  BIAS_S    = 10'(BIAS);
    localparam logic signed [9:0]  EXP_MAX_S = 10'(EXP_MAX);

    state_e                    state_q, state_d;
    logic                      sign_q, sign_d;
    logic signed [9:0]         exp_q, exp_d;
    logic [MANT_W-1:0]         mb_q, mb_d;
    logic [REM_W-1:0]          rem_q, rem_d;
    logic [QUO_W-1:0]          quo_q, quo_d;
    logic [4:0]                cnt_q, cnt_d;
    logic [31:0]               c_q, c_d;

    logic [REM_W-1:0]          step_rem;
    logic [ITER_PER_CYCLE-1:0] step_q;

    class_e                    cls_a, cls_b;
    logic                      special;
    logic [31:0]               special_res;

    logic signed [9:0]         norm_exp;
    logic [FRAC_W-1:0]         trunc_frac;
    logic [FRAC_W-1:0]         norm_frac;
    logic [31:0]               norm_res;

    fp_div_mant_step #(
        .ITER_PER_CYCLE(ITER_PER_CYCLE)
    ) u_step (
        .rem_i(rem_q),
        .div_i(mb_q),
        .rem_o(step_rem),
        .q_o  (step_q)
    );

    // Operand classification and special-case result, priority order top to bottom.
    always_comb begin
        cls_a       = classify(a);
        cls_b       = classify(b);
        special     = 1'b1;
        special_res = QNAN;
        if (cls_a == ClsNan || cls_b == ClsNan) begin
            special_res = QNAN;
        end else if ((cls_a == ClsZero && cls_b == ClsZero) ||
                     (cls_a == ClsInf && cls_b == ClsInf)) begin
            special_res = QNAN;
        end else if (cls_a == ClsInf || cls_b == ClsZero) begin
            special_res = {a[31] ^ b[31], INF_MAG};
        end else if (cls_a == ClsZero || cls_b == ClsInf) begin
            special_res = {a[31] ^ b[31], ZERO_MAG};
        end else begin
            special = 1'b0;
        end
    end

    // Normalise, optionally round, then pack with overflow/underflow saturation.
    always_comb begin
`ifdef FP_DIV_RNE_EN
        logic              guard;
        logic              sticky;
        logic [MANT_W:0]   mant_rnd;
`endif
        norm_exp   = quo_q[QUO_W-1] ? exp_q : exp_q - 10'sd1;
        trunc_frac = quo_q[QUO_W-1] ? quo_q[24:2] : quo_q[23:1];
`ifdef FP_DIV_RNE_EN
        guard    = quo_q[QUO_W-1] ? quo_q[1] : quo_q[0];
        sticky   = (|rem_q) | (quo_q[QUO_W-1] & quo_q[0]);
        mant_rnd = {2'b01, trunc_frac} + {24'd0, guard & (sticky | trunc_frac[0])};
        // Carry out of the hidden bit renormalises to 1.0 at the next exponent
        if (mant_rnd[MANT_W]) begin
            norm_exp = norm_exp + 10'sd1;
        end
        norm_frac = mant_rnd[MANT_W] ? mant_rnd[23:1] : mant_rnd[22:0];
`else
        norm_frac = trunc_frac;
`endif
        if (norm_exp >= EXP_MAX_S) begin
            norm_res = {sign_q, INF_MAG};
        end else if (norm_exp <= 10'sd0) begin
            norm_res = {sign_q, ZERO_MAG};
        end else begin
            norm_res = {sign_q, norm_exp[7:0], norm_frac};
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d = a[31] ^ b[31];
                    if (special) begin
                        c_d     = special_res;
                        state_d = StDone;
                    end else begin
                        exp_d   = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + BIAS_S;
                        mb_d    = {1'b1, b[22:0]};
                        rem_d   = {2'b01, a[22:0]};
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = StDiv;
                    end
                end
            end
            StDiv: begin
                rem_d = step_rem;
                quo_d = {quo_q[QUO_W-1-ITER_PER_CYCLE:0], step_q};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                c_d     = norm_res;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign c         = c_q;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed table, handshake/reset sequences, random vs model.
module tb_fp_divider;

    localparam int unsigned ITER     = 1;
    localparam int unsigned NDIV     = (26 + ITER - 1) / ITER;
    localparam int          LAT_NORM = NDIV + 2;
    localparam int          LAT_SPEC = 1;
    localparam int          TIMEOUT  = 200;
    localparam int          NRAND    = 250;

`ifdef FP_DIV_RNE_EN
    localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
    localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_divider #(
        .ITER_PER_CYCLE(ITER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c        (c)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Reference: exact integer quotient with the smaller mantissa pre-scaled, then round.
    function automatic logic [32:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        int              ex, ey, e;
        logic            s;
        logic [22:0]     fx, fy;
        bit              xz, xi, xn, yz, yi, yn;
        longint unsigned mx, my, q;
`ifdef FP_DIV_RNE_EN
        longint unsigned r;
`endif
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = x[22:0];
        fy = y[22:0];
        s  = x[31] ^ y[31];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (fx == 0);
        yi = (ey == 255) && (fy == 0);
        xn = (ex == 255) && (fx != 0);
        yn = (ey == 255) && (fy != 0);
        if (xn || yn) return {1'b1, 32'h7FC00000};
        if ((xz && yz) || (xi && yi)) return {1'b1, 32'h7FC00000};
        if (xi || yz) return {1'b1, s, 31'h7F800000};
        if (xz || yi) return {1'b1, s, 31'h00000000};
        mx = longint'(fx) + (64'd1 << 23);
        my = longint'(fy) + (64'd1 << 23);
        e  = ex - ey + 127;
        if (mx < my) begin
            mx = mx << 1;
            e  = e - 1;
        end
        q = (mx << 23) / my;
`ifdef FP_DIV_RNE_EN
        r = (mx << 23) % my;
        if ((2 * r > my) || ((2 * r == my) && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
`endif
        if (e >= 255) return {1'b0, s, 31'h7F800000};
        if (e <= 0) return {1'b0, s, 31'h00000000};
        return {1'b0, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] x;
        int unsigned mode;
        x    = $urandom;
        mode = $urandom_range(0, 9);
        if (mode <= 5) begin
            x[30:23] = 8'($urandom_range(100, 154));
        end else if (mode == 6) begin
            x[30:23] = 8'($urandom_range(1, 20));
        end else if (mode == 7) begin
            x[30:23] = 8'($urandom_range(235, 254));
        end else if (mode == 8) begin
            case ($urandom_range(0, 3))
                0:       x[30:0] = 31'h0;
                1:       x[30:23] = 8'h00;
                2:       x[30:0] = 31'h7F800000;
                default: x[30:23] = 8'hFF;
            endcase
        end
        return x;
    endfunction

    // One full transaction: accept, wait (bounded) for the result, then handshake it out.
    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = c;
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] res;
        logic [32:0] exp_r;
        logic [31:0] ra, rb;
        int          lat;

        vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, LAT_NORM});
        vecs.push_back('{32'h3F800000, 32'h40400000, ONE_THIRD,    LAT_NORM});
        vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, LAT_SPEC});
        vecs.push_back('{32'h80000000, 32'h00000000, 32'h7FC00000, LAT_SPEC});
        vecs.push_back('{32'hBF800000, 32'h7F800000, 32'h80000000, LAT_SPEC});
        vecs.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, LAT_NORM});
        vecs.push_back('{32'h00800000, 32'h4B000000, 32'h00000000, LAT_NORM});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, LAT_SPEC});
        vecs.push_back('{32'h00000000, 32'h7FC00000, 32'h7FC00000, LAT_SPEC});
        vecs.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, LAT_SPEC});
        vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, LAT_SPEC});
        vecs.push_back('{32'hC1000000, 32'h3F000000, 32'hC1800000, LAT_NORM});
        vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, LAT_SPEC});
        vecs.push_back('{32'h3F800000, 32'h80000001, 32'hFF800000, LAT_SPEC});
        vecs.push_back('{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, LAT_NORM});
        vecs.push_back('{32'h00800000, 32'h3F800001, 32'h00000000, LAT_NORM});
        vecs.push_back('{32'h3F800000, 32'h7F7FFFFF, 32'h00000000, LAT_NORM});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, LAT_NORM});

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_c", c, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_c %08h/%08h", i, vecs[i].a, vecs[i].b), res, vecs[i].c);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Output stall: result held, input side closed, new requests ignored.
        @(negedge clk);
        a        = 32'h40C00000;
        b        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall_lat", 32'(lat), 32'(LAT_NORM));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a        = 32'h3F800000;
            b        = 32'h00000000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall%0d_c", k), c, 32'h40400000);
            check($sformatf("stall%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_ignored_req", {31'd0, out_valid}, 32'd0);
        end

        // Reset in the middle of the divide aborts the operation.
        @(negedge clk);
        a        = 32'h3F800000;
        b        = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_c", c, 32'd0);
        repeat (LAT_NORM + 4) @(posedge clk);
        #1;
        check("abort_no_output", {31'd0, out_valid}, 32'd0);
        run_op(32'h40C00000, 32'h40000000, res, lat);
        check("after_abort_c", res, 32'h40400000);
        check("after_abort_lat", 32'(lat), 32'(LAT_NORM));

        for (int i = 0; i < NRAND; i++) begin
            ra    = rand_fp();
            rb    = rand_fp();
            exp_r = ref_div(ra, rb);
            run_op(ra, rb, res, lat);
            check($sformatf("rand%0d_c %08h/%08h", i, ra, rb), res, exp_r[31:0]);
            check($sformatf("rand%0d_lat", i), 32'(lat), exp_r[32] ? 32'(LAT_SPEC) : 32'(LAT_NORM));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
